// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: FSM states, ALU
// opcodes, Type-C func bit positions and the all-ones escape code.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } seq_state_t;

  localparam logic [2:0] OPC_ADD   = 3'b000;
  localparam logic [2:0] OPC_SUB   = 3'b001;
  localparam logic [2:0] OPC_AND   = 3'b010;
  localparam logic [2:0] OPC_OR    = 3'b011;
  localparam logic [2:0] OPC_NOT   = 3'b100;
  localparam logic [2:0] OPC_PASS  = 3'b101;
  localparam logic [2:0] OPC_MFROM = 3'b110;
  localparam logic [2:0] OPC_MUL   = 3'b111;

  localparam int FB_MOVETO   = 0;
  localparam int FB_MOVEFROM = 1;
  localparam int FB_ADD      = 2;
  localparam int FB_SUB      = 3;
  localparam int FB_AND      = 4;
  localparam int FB_OR       = 5;
  localparam int FB_NOT      = 6;
  localparam int FB_NOP      = 7;
  localparam int FB_MUL      = 8;

  // Escape code is all-ones at any opcode width; sliced down to OPC_W by users.
  localparam logic [7:0] TYPEC_ESC = 8'hFF;

  function automatic logic is_onehot9(input logic [8:0] f);
    return (f != 9'd0) && ((f & (f - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational Type-C decoder: maps aluOp/func to ALU opcode, flags and an
// illegal indication for zero, multi-hot or reserved-bit func codes.
module alu_func_decode
  import alu_seq_pkg::*;
#(
  parameter int OPC_W  = 3,
  parameter int FUNC_W = 9
) (
  input  logic [OPC_W-1:0]  op_class,
  input  logic [FUNC_W-1:0] func,
  output logic [OPC_W-1:0]  opc,
  output logic              no_op,
  output logic              move_to,
  output logic              multi,
  output logic              illegal
);

  localparam logic [OPC_W-1:0] TYPEC = TYPEC_ESC[OPC_W-1:0];

  logic [8:0] low_bits;
  logic       reserved_set;

  assign low_bits     = func[8:0];
  assign reserved_set = |(func >> 9);

  always_comb begin
    opc     = '0;
    no_op   = 1'b0;
    move_to = 1'b0;
    multi   = 1'b0;
    illegal = 1'b0;
    if (op_class != TYPEC) begin
      opc = op_class;
    end else if (!is_onehot9(low_bits) || reserved_set) begin
      illegal = 1'b1;
    end else begin
      // func is known one-hot here, so exactly one arm matches.
      case (1'b1)
        low_bits[FB_MOVETO]:   begin opc = OPC_W'(OPC_PASS); move_to = 1'b1; end
        low_bits[FB_MOVEFROM]: opc = OPC_W'(OPC_MFROM);
        low_bits[FB_ADD]:      opc = OPC_W'(OPC_ADD);
        low_bits[FB_SUB]:      opc = OPC_W'(OPC_SUB);
        low_bits[FB_AND]:      opc = OPC_W'(OPC_AND);
        low_bits[FB_OR]:       opc = OPC_W'(OPC_OR);
        low_bits[FB_NOT]:      opc = OPC_W'(OPC_NOT);
        low_bits[FB_NOP]:      begin opc = OPC_W'(OPC_PASS); no_op = 1'b1; end
        low_bits[FB_MUL]:      begin opc = OPC_W'(OPC_MUL); multi = 1'b1; end
        default:               illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: IDLE/EXEC/DONE handshake, multi-cycle MUL.
// Define ALU_SEQ_ILLEGAL_TRAP_EN for a sticky illegal flag and EXEC-skipping traps.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int FUNC_W  = 9,
  parameter int MUL_CYC = 16,
  parameter int CNT_W   = $clog2(MUL_CYC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [OPC_W-1:0]  aluOp,
  input  logic [FUNC_W-1:0] func,
  output logic              ready,
  output logic [OPC_W-1:0]  aluOpc,
  output logic              noOp,
  output logic              moveTo,
  output logic              multi,
  output logic              aluEn,
  output logic [CNT_W-1:0]  step,
  output logic              done,
  output logic              illegal
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(MUL_CYC - 1);

  seq_state_t       state, state_next;
  logic [OPC_W-1:0] dec_opc;
  logic             dec_no_op, dec_move_to, dec_multi, dec_illegal;
  logic             op_illegal;
  logic             accept;
  logic             exec_last;

  alu_func_decode #(.OPC_W(OPC_W), .FUNC_W(FUNC_W)) u_decode (
    .op_class (aluOp),
    .func     (func),
    .opc      (dec_opc),
    .no_op    (dec_no_op),
    .move_to  (dec_move_to),
    .multi    (dec_multi),
    .illegal  (dec_illegal)
  );

  assign accept    = (state == S_IDLE) && start && !flush;
  assign exec_last = !multi || (step == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          state_next = dec_illegal ? S_DONE : S_EXEC;
`else
          state_next = S_EXEC;
`endif
        end
      end
      S_EXEC:  if (exec_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  assign ready = (state == S_IDLE);
  assign aluEn = (state == S_EXEC) && !noOp && !op_illegal;

  // done stays combinational so a pulse coinciding with flush is still visible.
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign done = ((state == S_EXEC) && exec_last) || ((state == S_DONE) && op_illegal);
`else
  assign done = (state == S_EXEC) && exec_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluOpc     <= '0;
      noOp       <= 1'b0;
      moveTo     <= 1'b0;
      multi      <= 1'b0;
      op_illegal <= 1'b0;
      step       <= '0;
    end else if (flush) begin
      aluOpc     <= '0;
      noOp       <= 1'b0;
      moveTo     <= 1'b0;
      multi      <= 1'b0;
      op_illegal <= 1'b0;
      step       <= '0;
    end else if (accept) begin
      aluOpc     <= dec_opc;
      noOp       <= dec_no_op;
      moveTo     <= dec_move_to;
      multi      <= dec_multi;
      op_illegal <= dec_illegal;
      step       <= '0;
    end else if ((state == S_EXEC) && multi && (step != STEP_LAST)) begin
      step <= step + CNT_W'(1);
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        illegal <= 1'b0;
    else if (accept && dec_illegal) illegal <= 1'b1;
  end
`else
  assign illegal = op_illegal;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a done-driven scoreboard plus
// per-scenario tasks covering reset, decode, MUL sequencing, flush and throughput.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       flush;
  logic [2:0] aluOp;
  logic [8:0] func;
  logic       ready;
  logic [2:0] aluOpc;
  logic       noOp;
  logic       moveTo;
  logic       multi;
  logic       aluEn;
  logic [3:0] step;
  logic       done;
  logic       illegal;

  typedef struct {
    logic [2:0] opc;
    logic       no_op;
    logic       move_to;
    logic       multi;
    logic       ill;
    int         step;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [8:0] fn_tab  [8] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080};
  logic [2:0] opc_tab [8] = '{3'b101, 3'b110, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

  alu_op_sequencer #(.OPC_W(3), .FUNC_W(9), .MUL_CYC(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .aluOp   (aluOp),
    .func    (func),
    .ready   (ready),
    .aluOpc  (aluOpc),
    .noOp    (noOp),
    .moveTo  (moveTo),
    .multi   (multi),
    .aluEn   (aluEn),
    .step    (step),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [2:0] opc, input logic no_op, input logic move_to,
                              input logic mul, input logic ill, input int lat);
    exp_t e;
    e.opc = opc; e.no_op = no_op; e.move_to = move_to; e.multi = mul;
    e.ill = ill; e.lat = lat; e.step = lat - 1; e.t0 = 0;
    return e;
  endfunction

  // Scoreboard: every done pulse retires the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checks += 7;
        if (aluOpc !== e.opc) begin errors++; $display("[TB] FAIL sb_aluOpc got %b want %b", aluOpc, e.opc); end
        if (noOp !== e.no_op) begin errors++; $display("[TB] FAIL sb_noOp got %b want %b", noOp, e.no_op); end
        if (moveTo !== e.move_to) begin errors++; $display("[TB] FAIL sb_moveTo got %b want %b", moveTo, e.move_to); end
        if (multi !== e.multi) begin errors++; $display("[TB] FAIL sb_multi got %b want %b", multi, e.multi); end
        if (illegal !== e.ill) begin errors++; $display("[TB] FAIL sb_illegal got %b want %b", illegal, e.ill); end
        if (int'(step) != e.step) begin errors++; $display("[TB] FAIL sb_step got %0d want %0d", step, e.step); end
        if (cyc - e.t0 != e.lat) begin errors++; $display("[TB] FAIL sb_latency got %0d want %0d", cyc - e.t0, e.lat); end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [8:0] fn, input exp_t e);
    aluOp = op;
    func  = fn;
    start = 1'b1;
    e.t0  = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL wait_idle_timeout ready %b want 1", ready); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 4;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
    if (aluOpc !== 3'b000) begin errors++; $display("[TB] FAIL reset_aluOpc got %b want 000", aluOpc); end
    if (aluEn !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_en_done got %b%b want 00", aluEn, done); end
    if (step !== 4'd0 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_step_ill got %0d/%b want 0/0", step, illegal); end
    rst = 1'b0;
    @(negedge clk);
    issue(3'b111, 9'h100, mk(3'b111, 0, 0, 1, 0, 16));
    repeat (5) @(negedge clk);
    checks += 2;
    if (step !== 4'd5) begin errors++; $display("[TB] FAIL midmul_step got %0d want 5", step); end
    if (aluEn !== 1'b1) begin errors++; $display("[TB] FAIL midmul_aluEn got %b want 1", aluEn); end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready_done got %b%b want 10", ready, done); end
    if (aluEn !== 1'b0 || step !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_en_step got %b/%0d want 0/0", aluEn, step); end
    if (multi !== 1'b0 || aluOpc !== 3'b000) begin errors++; $display("[TB] FAIL async_reset_dec got %b/%b want 0/000", multi, aluOpc); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready got %b want 1", ready); end
  endtask

  task automatic test_single();
    issue(3'b010, 9'h000, mk(3'b010, 0, 0, 0, 0, 1));
    checks += 3;
    if (aluEn !== 1'b1) begin errors++; $display("[TB] FAIL single_aluEn got %b want 1", aluEn); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_done got %b want 1", done); end
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_t1 got %b want 0", ready); end
    @(negedge clk);
    checks += 2;
    if (ready !== 1'b0 || aluEn !== 1'b0) begin errors++; $display("[TB] FAIL single_donestate got %b%b want 00", ready, aluEn); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse got %b want 0", done); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_t3 got %b want 1", ready); end
  endtask

  task automatic test_typec();
    for (int i = 0; i < 8; i++) begin
      issue(3'b111, fn_tab[i], mk(opc_tab[i], i == 7, i == 0, 0, 0, 1));
      checks++;
      if (aluEn !== (i != 7)) begin errors++; $display("[TB] FAIL typec_aluEn func %h got %b want %b", fn_tab[i], aluEn, i != 7); end
      wait_idle();
    end
  endtask

  task automatic test_mul();
    issue(3'b111, 9'h100, mk(3'b111, 0, 0, 1, 0, 16));
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (aluEn !== 1'b1 || int'(step) != i || multi !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mul_cycle %0d got en %b step %0d multi %b want 1 %0d 1", i, aluEn, step, multi, i);
      end
      @(negedge clk);
    end
    checks++;
    if (aluEn !== 1'b0 || step !== 4'd15 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_donestate got en %b step %0d done %b want 0 15 0", aluEn, step, done);
    end
    wait_idle();
  endtask

  task automatic test_illegal();
    issue(3'b111, 9'h003, mk(3'b000, 0, 0, 0, 1, 1));
    checks += 2;
    if (illegal !== 1'b1 || aluOpc !== 3'b000) begin errors++; $display("[TB] FAIL ill_multihot got %b/%b want 1/000", illegal, aluOpc); end
    if (aluEn !== 1'b0) begin errors++; $display("[TB] FAIL ill_aluEn got %b want 0", aluEn); end
    wait_idle();
    issue(3'b111, 9'h000, mk(3'b000, 0, 0, 0, 1, 1));
    wait_idle();
    issue(3'b011, 9'h003, mk(3'b011, 0, 0, 0, TRAP, 1));
    checks++;
    if (illegal !== TRAP || aluEn !== 1'b1) begin errors++; $display("[TB] FAIL ill_after_legal got %b/%b want %b/1", illegal, aluEn, TRAP); end
    wait_idle();
    issue(3'b111, 9'h004, mk(3'b000, 0, 0, 0, TRAP, 1));
    wait_idle();
  endtask

  task automatic test_flush();
    exp_t e;
    issue(3'b111, 9'h100, mk(3'b111, 0, 0, 1, 0, 16));
    repeat (3) @(negedge clk);
    checks++;
    if (step !== 4'd3 || done !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre got step %0d done %b want 3 0", step, done); end
    void'(sb.pop_front());
    flush = 1'b1;
    start = 1'b1;
    aluOp = 3'b010;
    func  = 9'h000;
    @(negedge clk);
    checks += 3;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got ready %b done %b want 1 0", ready, done); end
    if (aluEn !== 1'b0 || step !== 4'd0) begin errors++; $display("[TB] FAIL flush_clear got en %b step %0d want 0 0", aluEn, step); end
    if (aluOpc !== 3'b000 || multi !== 1'b0) begin errors++; $display("[TB] FAIL flush_dec got %b/%b want 000/0", aluOpc, multi); end
    flush = 1'b0;
    e = mk(3'b010, 0, 0, 0, 0, 1);
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (aluOpc !== 3'b010 || aluEn !== 1'b1) begin errors++; $display("[TB] FAIL flush_restart got %b/%b want 010/1", aluOpc, aluEn); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = mk(3'b000, 0, 0, 0, 0, 1);
    e.t0 = cyc;
    sb.push_back(e);
    aluOp = 3'b000;
    func  = 9'h000;
    start = 1'b1;
    @(negedge clk);
    aluOp = 3'b001;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || aluOpc !== 3'b000) begin errors++; $display("[TB] FAIL b2b_ignored got ready %b opc %b want 0 000", ready, aluOpc); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b want 1", ready); end
    e = mk(3'b001, 0, 0, 0, 0, 1);
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (aluOpc !== 3'b001 || aluEn !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second got %b/%b want 001/1", aluOpc, aluEn); end
    wait_idle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    aluOp = 3'b000;
    func  = 9'h000;
    test_reset();
    test_single();
    test_typec();
    test_mul();
    test_illegal();
    test_flush();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
